// File: rtl/row_transfer_engine_pkg.sv
// ============================================================================
// Module      : row_transfer_engine_pkg
// Description : Shared definitions for the row transfer engine. Holds the
//               mode encodings, the FSM state type and a helper that builds
//               a DDR word address of the form {prefix, row, word}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package row_transfer_engine_pkg;

    // Transfer mode encodings (bit 0 = write phase, bit 1 = read phase)
    localparam logic [1:0] MODE_NONE       = 2'b00;
    localparam logic [1:0] MODE_WRITE      = 2'b01;
    localparam logic [1:0] MODE_READ       = 2'b10;
    localparam logic [1:0] MODE_WRITE_READ = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Builds {prefix, row, word} in a 64-bit container; the caller narrows
    // the result to its own address width.
    function automatic logic [63:0] compose_address(
        input logic [63:0] prefix,
        input logic [63:0] row,
        input logic [63:0] word,
        input int          row_bits,
        input int          word_bits
    );
        return (prefix << (row_bits + word_bits)) | (row << word_bits) | word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/row_transfer_engine_if.sv
// ============================================================================
// Module      : row_transfer_engine_if
// Description : Word-wide DDR controller handshake used by the row transfer
//               engine. master = engine side, slave = controller side.
//   write/writeAddress/writeData   : write request level, address and word
//   writeAcknowledge               : controller consumed one write word
//   read/readAddress               : read request level and address
//   readData/readAcknowledge       : one read word delivered
//   refresh                        : one-cycle refresh request pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface row_transfer_engine_if #(
    parameter int ADDR_BITS = 24,
    parameter int WORD_BITS = 16
);
    logic                 write;
    logic [ADDR_BITS-1:0] writeAddress;
    logic [WORD_BITS-1:0] writeData;
    logic                 writeAcknowledge;
    logic                 read;
    logic [ADDR_BITS-1:0] readAddress;
    logic [WORD_BITS-1:0] readData;
    logic                 readAcknowledge;
    logic                 refresh;

    modport master (
        output write, writeAddress, writeData,
        input  writeAcknowledge,
        output read, readAddress,
        input  readData, readAcknowledge,
        output refresh
    );

    modport slave (
        input  write, writeAddress, writeData,
        output writeAcknowledge,
        input  read, readAddress,
        output readData, readAcknowledge,
        input  refresh
    );
endinterface

`default_nettype wire

// File: rtl/row_transfer_engine_row_word_mux.sv
// ============================================================================
// Module      : row_word_mux
// Description : Selects one WORD_BITS-wide word out of a ROW_BITS-wide row.
//   row   : full row, word k at bits [k*WORD_BITS +: WORD_BITS]
//   index : word number to select
//   word  : selected word (zero for an index past the last word)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_word_mux #(
    parameter int ROW_BITS   = 640,
    parameter int WORD_BITS  = 16,
    parameter int INDEX_BITS = 6
) (
    input  logic [ROW_BITS-1:0]   row,
    input  logic [INDEX_BITS-1:0] index,
    output logic [WORD_BITS-1:0]  word
);
    localparam int WORDS = ROW_BITS / WORD_BITS;

    logic [WORD_BITS-1:0] w_words [WORDS];

    generate
        for (genvar k = 0; k < WORDS; k++) begin : g_word
            assign w_words[k] = row[k*WORD_BITS +: WORD_BITS];
        end
    endgenerate

    always_comb begin
        word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (index == INDEX_BITS'(k)) begin
                word = w_words[k];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/row_transfer_engine.sv
// ============================================================================
// Module      : row_transfer_engine
// Description : Snapshots a display row on start, writes it to DDR one word
//               per acknowledge at {BASE, writeRowIndex, word}, then
//               optionally reads a row from {BASE, readRowIndex, word} into
//               readRow. Modes: 01 write-only, 10 read-only, 11 both.
// Ports       : clk, rst (async, active-low), start, mode, writeRowIndex,
//               readRowIndex, writeRow, readRow, busy, done, ddr (master
//               side of row_transfer_engine_if).
// Options     : ROW_XFER_REFRESH_EN - when defined, refresh pulses on phase
//               entry, every REFRESH_INTERVAL-th acknowledge and the final
//               word of a phase; otherwise refresh is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_transfer_engine
    import row_transfer_engine_pkg::*;
#(
    parameter int          ROW_BITS         = 640,
    parameter int          WORD_BITS        = 16,
    parameter int          ROW_INDEX_BITS   = 9,
    parameter int          WORD_INDEX_BITS  = 6,
    parameter int          ADDR_BITS        = 24,
    parameter int unsigned BASE             = 1,
    parameter int          REFRESH_INTERVAL = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [ROW_INDEX_BITS-1:0] writeRowIndex,
    input  logic [ROW_INDEX_BITS-1:0] readRowIndex,
    input  logic [ROW_BITS-1:0]       writeRow,
    output logic [ROW_BITS-1:0]       readRow,
    output logic                      busy,
    output logic                      done,
    row_transfer_engine_if.master     ddr
);
    localparam int WORDS = ROW_BITS / WORD_BITS;
    localparam logic [WORD_INDEX_BITS-1:0] c_LAST_WORD = WORD_INDEX_BITS'(WORDS - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [WORD_INDEX_BITS-1:0] r_word_idx;
    logic [ROW_BITS-1:0]       r_snapshot;
    logic [ROW_INDEX_BITS-1:0] r_write_row_index;
    logic [ROW_INDEX_BITS-1:0] r_read_row_index;
    logic [1:0]                r_mode;
    logic                      w_accept;
    logic                      w_write_ack;
    logic                      w_read_ack;
    logic                      w_last_word;
    logic [WORD_BITS-1:0]      w_write_word;
    logic [ADDR_BITS-1:0]      w_write_address;
    logic [ADDR_BITS-1:0]      w_read_address;

    // Acks only count in the phase they belong to
    assign w_accept    = (r_state == ST_IDLE) && start && (mode != MODE_NONE);
    assign w_write_ack = (r_state == ST_WRITE) && ddr.writeAcknowledge;
    assign w_read_ack  = (r_state == ST_READ) && ddr.readAcknowledge;
    assign w_last_word = (r_word_idx == c_LAST_WORD);

    assign w_write_address = ADDR_BITS'(compose_address(64'(BASE), 64'(r_write_row_index),
                                  64'(r_word_idx), ROW_INDEX_BITS, WORD_INDEX_BITS));
    assign w_read_address  = ADDR_BITS'(compose_address(64'(BASE), 64'(r_read_row_index),
                                  64'(r_word_idx), ROW_INDEX_BITS, WORD_INDEX_BITS));

    row_word_mux #(
        .ROW_BITS   (ROW_BITS),
        .WORD_BITS  (WORD_BITS),
        .INDEX_BITS (WORD_INDEX_BITS)
    ) u_write_mux (
        .row   (r_snapshot),
        .index (r_word_idx),
        .word  (w_write_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are decoded from the state so they are zero outside a phase
    always_comb begin
        w_state_next     = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        ddr.write        = 1'b0;
        ddr.writeAddress = '0;
        ddr.writeData    = '0;
        ddr.read         = 1'b0;
        ddr.readAddress  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (mode == MODE_READ) ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy             = 1'b1;
                ddr.write        = 1'b1;
                ddr.writeAddress = w_write_address;
                ddr.writeData    = w_write_word;
                if (w_write_ack && w_last_word) begin
                    w_state_next = (r_mode == MODE_WRITE_READ) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                busy            = 1'b1;
                ddr.read        = 1'b1;
                ddr.readAddress = w_read_address;
                if (w_read_ack && w_last_word) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Word counter wraps to zero at each phase end, which also makes it the
    // word-0 index for the read phase on the write-to-read handover edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_idx        <= '0;
            r_snapshot        <= '0;
            r_write_row_index <= '0;
            r_read_row_index  <= '0;
            r_mode            <= MODE_NONE;
            readRow           <= '0;
        end else begin
            if (w_accept) begin
                r_word_idx        <= '0;
                r_snapshot        <= writeRow;
                r_write_row_index <= writeRowIndex;
                r_read_row_index  <= readRowIndex;
                r_mode            <= mode;
            end else if (w_write_ack || w_read_ack) begin
                r_word_idx <= w_last_word ? '0 : r_word_idx + 1'b1;
            end
            if (w_read_ack) begin
                readRow[r_word_idx*WORD_BITS +: WORD_BITS] <= ddr.readData;
            end
        end
    end

`ifdef ROW_XFER_REFRESH_EN
    localparam int REF_CNT_BITS = $clog2(REFRESH_INTERVAL + 1);

    logic [REF_CNT_BITS-1:0] r_ref_cnt;
    logic                    r_refresh;
    logic                    w_phase_ack;
    logic                    w_interval_hit;

    assign w_phase_ack    = w_write_ack || w_read_ack;
    assign w_interval_hit = w_phase_ack && (r_ref_cnt == REF_CNT_BITS'(REFRESH_INTERVAL - 1));

    // The last write ack is also the read-phase entry, so OR-ing the causes
    // yields a single pulse for that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_cnt <= '0;
            r_refresh <= 1'b0;
        end else begin
            r_refresh <= w_accept || w_interval_hit || (w_phase_ack && w_last_word);
            if (w_accept || w_interval_hit || (w_phase_ack && w_last_word)) begin
                r_ref_cnt <= '0;
            end else if (w_phase_ack) begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
        end
    end

    assign ddr.refresh = r_refresh;
`else
    assign ddr.refresh = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_row_transfer_engine.sv
`timescale 1ns/1ps
`default_nettype none

module tb_row_transfer_engine;
    localparam int ROW_BITS  = 640;
    localparam int WORD_BITS = 16;
    localparam int ADDR_BITS = 24;
    localparam int WORDS     = 40;
    localparam int REF_INT   = 18;
    localparam logic [8:0] BASE_PREFIX = 9'd1;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic [8:0]          writeRowIndex = '0;
    logic [8:0]          readRowIndex = '0;
    logic [ROW_BITS-1:0] writeRow = '0;
    logic [ROW_BITS-1:0] readRow;
    logic                busy;
    logic                done;

    row_transfer_engine_if #(.ADDR_BITS(ADDR_BITS), .WORD_BITS(WORD_BITS)) ddr_if ();

    row_transfer_engine dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .writeRowIndex (writeRowIndex),
        .readRowIndex  (readRowIndex),
        .writeRow      (writeRow),
        .readRow       (readRow),
        .busy          (busy),
        .done          (done),
        .ddr           (ddr_if)
    );

    always #5 clk = ~clk;

    int                  n_tests = 0;
    int                  n_fail  = 0;
    wr_t                 exp_wr_q[$];
    logic [23:0]         exp_rd_q[$];
    int                  exp_ref_q[$];
    logic [ROW_BITS-1:0] exp_read_row = '0;
    logic [15:0]         rd_xor = '0;
    int                  done_cnt;
    int                  done_cyc;

    function automatic logic [ROW_BITS-1:0] rand_row();
        logic [ROW_BITS-1:0] r;
        for (int i = 0; i < ROW_BITS / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drives a start pulse and pushes the expected bus traffic
    task automatic launch(input logic [1:0] m, input logic [8:0] wi, input logic [8:0] ri,
                          input logic [ROW_BITS-1:0] row);
        int w_n;
        wr_t t;
        @(negedge clk);
        mode = m; writeRowIndex = wi; readRowIndex = ri; writeRow = row; start = 1'b1;
        w_n = m[0] ? WORDS : 0;
        if (m[0]) begin
            for (int k = 0; k < WORDS; k++) begin
                t.addr = {BASE_PREFIX, wi, 6'(k)};
                t.data = row[k*WORD_BITS +: WORD_BITS];
                exp_wr_q.push_back(t);
            end
        end
        if (m[1]) begin
            for (int k = 0; k < WORDS; k++) begin
                exp_rd_q.push_back({BASE_PREFIX, ri, 6'(k)});
                exp_read_row[k*WORD_BITS +: WORD_BITS] = rd_xor ^ 16'(k);
            end
        end
`ifdef ROW_XFER_REFRESH_EN
        // key = writes_acked*100 + reads_acked when the pulse is seen
        exp_ref_q.push_back(0);
        if (m[0]) begin
            for (int k = 1; k <= WORDS; k++)
                if ((k % REF_INT) == 0 || k == WORDS) exp_ref_q.push_back(k * 100);
        end
        if (m[1]) begin
            for (int k = 1; k <= WORDS; k++)
                if ((k % REF_INT) == 0 || k == WORDS) exp_ref_q.push_back(w_n * 100 + k);
        end
`else
        w_n = w_n;
`endif
    endtask

    // Controller model + scoreboard: acks requests, pops expectations
    task automatic serve(input int max_gap, input int poke_cycle, input bit poke_on_done,
                         input bit stray, input int abort_at);
        int  cyc = 0;
        int  wr_n = 0;
        int  rd_n = 0;
        int  gap;
        int  key;
        bit  seen_done = 1'b0;
        wr_t e;
        logic [23:0] ea;
        done_cnt = 0; done_cyc = -1;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_cycle);
            if (cyc == 1) begin
                // inputs after acceptance must not leak into the transfer
                writeRow = ~writeRow; writeRowIndex += 9'd3; readRowIndex += 9'd5; mode = 2'b11;
            end
            ddr_if.writeAcknowledge = 1'b0;
            ddr_if.readAcknowledge  = 1'b0;
            if (ddr_if.refresh === 1'b1) begin
                key = wr_n * 100 + rd_n;
                n_tests++;
                if (exp_ref_q.size() == 0) begin
                    n_fail++; $display("FAIL refresh_unexpected: got pulse at %0d, required none", key);
                end else if (exp_ref_q[0] !== key) begin
                    n_fail++; $display("FAIL refresh_point: got %0d, required %0d", key, exp_ref_q[0]);
                    void'(exp_ref_q.pop_front());
                end else void'(exp_ref_q.pop_front());
            end
            if (seen_done) begin
                n_tests++;
                if ({busy, done} !== 2'b00) begin
                    n_fail++; $display("FAIL post_done busy/done: got %b, required 00", {busy, done});
                end
                break;
            end
            if (done === 1'b1) begin
                done_cnt++; done_cyc = cyc; seen_done = 1'b1;
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL busy_at_done: got %b, required 1", busy);
                end
                if (poke_on_done) start = 1'b1;
            end
            if (abort_at >= 0 && wr_n == abort_at && ddr_if.write === 1'b1) begin
                rst = 1'b0;
                break;
            end
            if (ddr_if.write === 1'b1) begin
                if (gap > 0) gap--;
                else begin
                    n_tests++;
                    if (exp_wr_q.size() == 0) begin
                        n_fail++; $display("FAIL wr_unexpected: got addr %h, required no write", ddr_if.writeAddress);
                    end else begin
                        e = exp_wr_q.pop_front();
                        if ({ddr_if.writeAddress, ddr_if.writeData} !== {e.addr, e.data}) begin
                            n_fail++;
                            $display("FAIL wr_word[%0d]: got %h/%h, required %h/%h", wr_n,
                                     ddr_if.writeAddress, ddr_if.writeData, e.addr, e.data);
                        end
                    end
                    ddr_if.writeAcknowledge = 1'b1; wr_n++;
                    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                end
            end else if (stray) ddr_if.writeAcknowledge = 1'b1;
            if (ddr_if.read === 1'b1) begin
                if (gap > 0) gap--;
                else begin
                    n_tests++;
                    if (exp_rd_q.size() == 0) begin
                        n_fail++; $display("FAIL rd_unexpected: got addr %h, required no read", ddr_if.readAddress);
                    end else begin
                        ea = exp_rd_q.pop_front();
                        if (ddr_if.readAddress !== ea) begin
                            n_fail++; $display("FAIL rd_addr[%0d]: got %h, required %h", rd_n, ddr_if.readAddress, ea);
                        end
                    end
                    ddr_if.readData = rd_xor ^ 16'(rd_n);
                    ddr_if.readAcknowledge = 1'b1; rd_n++;
                    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                end
            end else if (stray) begin
                ddr_if.readData = 16'hDEAD; ddr_if.readAcknowledge = 1'b1;
            end
            if (cyc > 3000) begin
                n_tests++; n_fail++;
                $display("FAIL timeout: got no done in %0d cycles, required done", cyc);
                break;
            end
        end
        start = 1'b0;
        ddr_if.writeAcknowledge = 1'b0;
        ddr_if.readAcknowledge  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, ddr_if.write, ddr_if.read, ddr_if.refresh} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, required 00000",
                                {busy, done, ddr_if.write, ddr_if.read, ddr_if.refresh});
        end
        n_tests++;
        if ({ddr_if.writeAddress, ddr_if.writeData, ddr_if.readAddress} !== 64'b0) begin
            n_fail++; $display("FAIL reset_bus: got %h %h %h, required 0",
                                ddr_if.writeAddress, ddr_if.writeData, ddr_if.readAddress);
        end
        n_tests++;
        if (readRow !== '0) begin
            n_fail++; $display("FAIL reset_readRow: got nonzero %h, required 0", readRow[63:0]);
        end
        rst = 1'b1;
    endtask

    task automatic check_end(input string name, input int want_cyc);
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++; $display("FAIL %s done_count: got %0d, required 1", name, done_cnt);
        end
        if (want_cyc > 0) begin
            n_tests++;
            if (done_cyc !== want_cyc) begin
                n_fail++; $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc, want_cyc);
            end
        end
        n_tests++;
        if ((exp_wr_q.size() + exp_rd_q.size() + exp_ref_q.size()) !== 0) begin
            n_fail++; $display("FAIL %s leftover wr/rd/ref: got %0d/%0d/%0d, required 0/0/0", name,
                                exp_wr_q.size(), exp_rd_q.size(), exp_ref_q.size());
        end
        n_tests++;
        if (readRow !== exp_read_row) begin
            n_fail++; $display("FAIL %s readRow: got %h, required %h", name, readRow[79:0], exp_read_row[79:0]);
        end
    endtask

    task automatic test_write_read();
        rd_xor = 16'h5A00;
        launch(2'b11, 9'd5, 9'd7, rand_row());
        serve(0, 0, 1'b0, 1'b0, -1);
        check_end("write_read", 81);
    endtask

    task automatic test_write_only();
        launch(2'b01, 9'd300, 9'd2, rand_row());
        serve(0, 0, 1'b0, 1'b1, -1);
        check_end("write_only", 41);
    endtask

    task automatic test_read_only();
        rd_xor = 16'h0000;
        launch(2'b10, 9'd1, 9'h1FF, rand_row());
        serve(0, 0, 1'b0, 1'b1, -1);
        check_end("read_only", 41);
        for (int k = 0; k < WORDS; k += 13) begin
            n_tests++;
            if (readRow[k*WORD_BITS +: WORD_BITS] !== 16'(k)) begin
                n_fail++; $display("FAIL read_only word[%0d]: got %h, required %h", k,
                                    readRow[k*WORD_BITS +: WORD_BITS], 16'(k));
            end
        end
    endtask

    task automatic test_random_gaps();
        int busy_seen = 0;
        rd_xor = 16'($urandom);
        launch(2'b11, 9'($urandom), 9'($urandom), rand_row());
        serve(5, 10, 1'b1, 1'b0, -1);
        check_end("random_gaps", 0);
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        n_tests++;
        if (busy_seen !== 0) begin
            n_fail++; $display("FAIL ignored_start busy cycles: got %0d, required 0", busy_seen);
        end
    endtask

    task automatic test_mode_zero();
        int active = 0;
        @(negedge clk);
        mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            if ({busy, ddr_if.write, ddr_if.read} !== 3'b000) active++;
            @(negedge clk);
        end
        n_tests++;
        if (active !== 0) begin
            n_fail++; $display("FAIL mode_zero active cycles: got %0d, required 0", active);
        end
    endtask

    task automatic test_reset_abort();
        launch(2'b11, 9'd11, 9'd12, rand_row());
        serve(0, 0, 1'b0, 1'b0, 20);
        #1;
        n_tests++;
        if ({busy, done, ddr_if.write, ddr_if.read, ddr_if.refresh, ddr_if.writeAddress} !== 29'b0) begin
            n_fail++; $display("FAIL abort_outputs: got %b %h, required 0",
                                {busy, done, ddr_if.write, ddr_if.read, ddr_if.refresh}, ddr_if.writeAddress);
        end
        exp_wr_q.delete(); exp_rd_q.delete(); exp_ref_q.delete();
        exp_read_row = '0;
        @(posedge clk); #1;
        n_tests++;
        if ({done, busy, readRow} !== '0) begin
            n_fail++; $display("FAIL abort_held: got done=%b busy=%b, required 0", done, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        rd_xor = 16'hC3C3;
        launch(2'b11, 9'd20, 9'd21, rand_row());
        serve(0, 0, 1'b0, 1'b0, -1);
        check_end("after_abort", 81);
    endtask

    initial begin
        ddr_if.writeAcknowledge = 1'b0;
        ddr_if.readAcknowledge  = 1'b0;
        ddr_if.readData         = '0;
        test_reset();
        test_write_read();
        test_write_only();
        test_read_only();
        test_mode_zero();
        test_random_gaps();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
